// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: phase encoding, lamp codes, phase order.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package traffic_pkg;

  // Phase order follows the declaration order; CLR2 wraps back to NS_G.
  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    CLR1 = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    CLR2 = 3'd5
  } phase_t;

  // Lamp field layout is {R,Y,G}, one-hot.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return CLR1;
      CLR1:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return CLR2;
      default: return NS_G;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_sync.sv
// Synchronizes an asynchronous slow clock and turns each rising edge into a 1-cycle tick.
// Latency: tick_o rises 3 clk_i edges after the input rise; it is exactly one cycle wide.
// Backpressure: none; input pulses shorter than 2 clk_i cycles may be lost.
module tick_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic tick_o
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_tick;

  // Two-flop synchronizer, a third flop for edge history, and a registered rising-edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= async_i;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_tick <= r_s2 & ~r_s3;
    end
  end

  assign tick_o = r_tick;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-direction traffic-light phase sequencer driven by ticks from a synchronized slow clock.
// Latency: phase/remain update 4 clk_i edges after a slow-clock rise; ped request visible after 1 edge.
// Backpressure: pause_i discards (does not queue) ticks; lamps and countdown hold while paused.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T   = 15,
  parameter int YELLOW_T  = 3,
  parameter int RED_CLR_T = 1,
  parameter int PED_T     = 2,
  parameter int CNT_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             slow_clk_i,
  input  logic             pause_i,
  input  logic             ped_req_i,
  output logic [2:0]       ns_light_o,
  output logic [2:0]       ew_light_o,
  output logic [CNT_W-1:0] remain_o,
  output logic             tick_o,
  output logic             ped_pend_o
);

  localparam int MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int MAX_T  = (MAX_GY > RED_CLR_T) ? MAX_GY : RED_CLR_T;

  if (GREEN_T < 3) begin : g_bad_green
    $error("traffic_phase_ctrl: GREEN_T must be >= 3");
  end
  if (YELLOW_T < 1) begin : g_bad_yellow
    $error("traffic_phase_ctrl: YELLOW_T must be >= 1");
  end
  if (RED_CLR_T < 1) begin : g_bad_clr
    $error("traffic_phase_ctrl: RED_CLR_T must be >= 1");
  end
  if (PED_T < 1 || PED_T >= GREEN_T) begin : g_bad_ped
    $error("traffic_phase_ctrl: PED_T must be >= 1 and < GREEN_T");
  end
  if (CNT_W < 1 || CNT_W > 30 || MAX_T >= (1 << CNT_W)) begin : g_bad_cnt
    $error("traffic_phase_ctrl: CNT_W too narrow for the longest phase");
  end

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] w_remain_nxt;
  logic             r_ped_pend;
  logic             w_ped_nxt;
  logic             w_tick;
  logic             w_act;
  logic             w_green;
  logic             w_cut;
  logic             w_enter_y;
  logic [2:0]       w_ns;
  logic [2:0]       w_ew;

  function automatic logic [CNT_W-1:0] phase_dur(input phase_t p);
    case (p)
      NS_G, EW_G: return CNT_W'(GREEN_T);
      NS_Y, EW_Y: return CNT_W'(YELLOW_T);
      default:    return CNT_W'(RED_CLR_T);
    endcase
  endfunction

  tick_sync u_tick_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(slow_clk_i),
    .tick_o (w_tick)
  );

  assign w_act = w_tick & ~pause_i;

  // Phase, countdown and pedestrian latch registers; reset lands in all-red clearance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase    <= CLR2;
      r_remain   <= CNT_W'(RED_CLR_T);
      r_ped_pend <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_remain   <= w_remain_nxt;
      r_ped_pend <= w_ped_nxt;
    end
  end

  // Next phase/countdown on an active tick, pedestrian latch update, and lamp decode of the registered phase.
  always_comb begin
    w_phase_nxt  = r_phase;
    w_remain_nxt = r_remain;
    w_green      = (r_phase == NS_G) || (r_phase == EW_G);
    w_cut        = w_green && r_ped_pend && (r_remain > CNT_W'(PED_T));
    w_ns         = LAMP_R;
    w_ew         = LAMP_R;

    if (w_act) begin
      if (w_cut) begin
        // A pedestrian cut only shortens green; the phase itself does not move.
        w_remain_nxt = CNT_W'(PED_T);
      end else if (r_remain == CNT_W'(1)) begin
        w_phase_nxt  = next_phase(r_phase);
        w_remain_nxt = phase_dur(w_phase_nxt);
      end else begin
        w_remain_nxt = r_remain - CNT_W'(1);
      end
    end

    w_enter_y = (w_phase_nxt != r_phase) && ((w_phase_nxt == NS_Y) || (w_phase_nxt == EW_Y));
    // A new request in the same cycle as yellow entry survives to cut the next green.
    w_ped_nxt = ped_req_i ? 1'b1 : (w_enter_y ? 1'b0 : r_ped_pend);

    case (r_phase)
      NS_G:    w_ns = LAMP_G;
      NS_Y:    w_ns = LAMP_Y;
      EW_G:    w_ew = LAMP_G;
      EW_Y:    w_ew = LAMP_Y;
      default: begin
        w_ns = LAMP_R;
        w_ew = LAMP_R;
      end
    endcase
  end

  assign ns_light_o = w_ns;
  assign ew_light_o = w_ew;
  assign remain_o   = r_remain;
  assign tick_o     = w_tick;
  assign ped_pend_o = r_ped_pend;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Consumer end of the slow-clock path. The block takes the divided slow clock produced elsewhere in the design as an ordinary data input and synchronizes it into the `clk_i` domain. It converts each slow-clock rising edge into a one-cycle tick. It uses those ticks to run a two-direction (NS/EW) traffic-light phase sequencer, with a countdown value for the display and a latched pedestrian request that shortens the current green.

## Interface
Parameters:
- `GREEN_T`, default 15: green duration in ticks. Must be ≥ 3.
- `YELLOW_T`, default 3: yellow duration in ticks. Must be ≥ 1.
- `RED_CLR_T`, default 1: all-red clearance in ticks. Must be ≥ 1.
- `PED_T`, default 2: remaining green after a pedestrian cut. Must be ≥ 1 and < `GREEN_T`.
- `CNT_W`, default 5: countdown width. Must hold `max(GREEN_T, YELLOW_T, RED_CLR_T)`.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `slow_clk_i`, in, 1: divided slow clock, treated as asynchronous.
- `pause_i`, in, 1: freeze the sequencer.
- `ped_req_i`, in, 1: pedestrian request, level or pulse.
- `ns_light_o`, out, 3: NS lamps `{R,Y,G}`, one-hot.
- `ew_light_o`, out, 3: EW lamps `{R,Y,G}`, one-hot.
- `remain_o`, out, `CNT_W`: ticks left in the current phase.
- `tick_o`, out, 1: one-cycle tick, registered.
- `ped_pend_o`, out, 1: pedestrian request latched.

## Operation
- Tick generation:
  - Three flops: `s1 <= slow_clk_i`, `s2 <= s1`, `s3 <= s2`.
  - `tick_o <= s2 & ~s3`.
  - All four flops reset to 0.
  - Falling edges of `slow_clk_i` produce nothing.
- Phases and their lamps:
  - `NS_G`: NS=100... no — NS=001, EW=100.
  - `NS_Y`: NS=010, EW=100.
  - `CLR1`: NS=100, EW=100.
  - `EW_G`: NS=100, EW=001.
  - `EW_Y`: NS=100, EW=010.
  - `CLR2`: NS=100, EW=100.
  - Order is cyclic: `NS_G → NS_Y → CLR1 → EW_G → EW_Y → CLR2 → NS_G`.
- Countdown:
  - Acts only on a cycle where `tick_o`=1 and `pause_i`=0.
  - If `remain`==1: advance to the next phase and load that phase's duration.
  - Otherwise: `remain <= remain-1`.
- Pedestrian cut:
  - `ped_pend` sets when `ped_req_i`=1.
  - It clears on entry to `NS_Y` or `EW_Y`.
  - If set and clear occur in the same cycle, set wins.
  - On an active tick in `NS_G`/`EW_G` with `ped_pend`=1 and `remain` > `PED_T`: `remain <= PED_T`. This replaces the normal decrement; the phase is not changed.
- Pause:
  - Ticks arriving while `pause_i`=1 are discarded, not queued.
  - Lamps and `remain` hold while paused.
  - `ped_pend` still sets while paused.
- Safety invariant: at least one direction shows R in every cycle. The two G lamps are never both asserted.
- Values after reset:
  - Phase `CLR2`.
  - `remain_o`=`RED_CLR_T`.
  - NS=100, EW=100.
  - `tick_o`=0, `ped_pend_o`=0.
- Reset mid-phase aborts immediately to the reset values. No lamp glitch: lamp outputs are decoded from registered state.

## Timing
- `slow_clk_i` rising before `clk_i` edge E1 gives `tick_o`=1 after E3 and 0 after E4. Latency is 3 edges; width is exactly 1 cycle.
- `slow_clk_i` high or low periods must each be ≥ 2 `clk_i` cycles. Shorter pulses may be lost; this is accepted.
- Phase and `remain` update on the edge after `tick_o`=1, i.e. 4 edges after the slow-clock rise.
- Lamps change on the same edge as the phase.
- `ped_req_i` is registered. It is visible on `ped_pend_o` 1 cycle later and takes effect on the next active tick.
- `pause_i` is sampled in the same cycle as `tick_o`.

## Structure
- Package `traffic_pkg` holds:
  - The phase enum: `NS_G, NS_Y, CLR1, EW_G, EW_Y, CLR2`.
  - Lamp constants: `LAMP_R`=3'b100, `LAMP_Y`=3'b010, `LAMP_G`=3'b001.
- Sub-module `tick_sync`, ports `clk_i, rst_i, async_i, tick_o`, contains the 3-flop synchronizer and rising-edge detect.
- Top level holds the phase FSM, the countdown and the pedestrian latch.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
Benches use `GREEN_T`=4, `YELLOW_T`=2, `RED_CLR_T`=1, `PED_T`=2, and `slow_clk_i` period 8 `clk_i` cycles (4 high, 4 low).
- **Reset:** assert `rst_i` mid-`EW_G` → outputs return immediately to NS=100, EW=100, `remain_o`=1, `tick_o`=0, `ped_pend_o`=0.
- **Tick:** single `slow_clk_i` rise → `tick_o` high exactly 1 cycle, 3 edges later. Holding `slow_clk_i` high for 20 cycles → no further ticks.
- **Full cycle:** run 14 ticks from reset → phase sequence `CLR2(1), NS_G(4,3,2,1), NS_Y(2,1), CLR1(1), EW_G(4..1), EW_Y(2,1), CLR2(1)`. Both directions are never non-red together.
- **Pedestrian:** pulse `ped_req_i` when `NS_G` `remain`=4 → next tick gives `remain`=2, then 1, then `NS_Y`. `ped_pend_o` clears on `NS_Y` entry. A request at `remain`=2 causes no change.
- **Pause:** hold `pause_i` across 3 ticks in `EW_Y` `remain`=2 → lamps and `remain` unchanged. The first tick after release gives `remain`=1.
- **Simultaneous set/clear:** `ped_req_i`=1 on the cycle of `NS_Y` entry → `ped_pend_o` stays 1, and the following `EW_G` is cut to `PED_T`.
